// File: rtl/complex_alu_seq_if.sv
// Command, sample-handshake, ALU-control and result-tag bundle for complex_alu_seq.
//   master : command/sample producer (drives cmd_*, in_valid; observes the rest)
//   slave  : the sequencer (consumes cmd_*, in_valid; drives readies, control words, tags, status)
interface complex_alu_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alumode;
  logic [19:0] inmode;
  logic [27:0] opmode;
  logic [3:0]  cea2;
  logic [3:0]  ceb2;
  logic [3:0]  usemult;
  logic        out_valid;
  logic        out_last;
  logic        done;
  logic        busy;

  modport master (
    output cmd_valid, cmd_op, cmd_len, in_valid,
    input  cmd_ready, in_ready, alumode, inmode, opmode, cea2, ceb2, usemult,
           out_valid, out_last, done, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, in_valid,
    output cmd_ready, in_ready, alumode, inmode, opmode, cea2, ceb2, usemult,
           out_valid, out_last, done, busy
  );
endinterface

// File: rtl/complex_alu_seq.sv
// Sequencer driving four identical complex-multiplier ALU lanes.
// Accepts a command (CMUL streams products, CMAC accumulates), issues one
// registered control word per cycle while samples arrive, then drains the
// ALU pipeline and pulses done. A tag pipeline marks which ALU outputs are
// valid/last, ALU_LAT cycles after the word that produced them.
//   clk, rst : clock, synchronous active-high reset
//   alu_if   : command/sample handshakes, lane control words, result tags, status
module complex_alu_seq #(
  parameter int unsigned ALU_LAT = 5
) (
  input  logic              clk,
  input  logic              rst,
  complex_alu_seq_if.slave  alu_if
);

  localparam int unsigned CNT_W  = 9;
  localparam int unsigned DCNT_W = $clog2(ALU_LAT + 1);
  localparam int unsigned OPM_W  = 7;

  localparam logic [OPM_W-1:0] OPM_LOAD = 7'b0000101;
  localparam logic [OPM_W-1:0] OPM_ACC  = 7'b0100101;
  localparam logic [OPM_W-1:0] OPM_HOLD = 7'b0100000;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              state_q;
  logic                op_q;      // 0 = CMUL, 1 = CMAC
  logic [CNT_W-1:0]    len_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DCNT_W-1:0]   dcnt_q;
  logic [OPM_W-1:0]    opm_q;
  logic                ce_q;
  logic                um_q;
  logic [1:0]          tag_q;     // {valid, last} of the word currently presented
  logic                done_q;
  logic [1:0]          tag_sr_q [ALU_LAT];

  logic [CNT_W-1:0]    cnt_d;
  logic                cmd_hs;
  logic                last_smp;

  assign cnt_d    = cnt_q + CNT_W'(1);
  assign cmd_hs   = alu_if.cmd_valid && (state_q == S_IDLE);
  assign last_smp = (cnt_d == len_q);

  // Sequencer FSM with registered control word, tag and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      opm_q   <= '0;
      ce_q    <= 1'b0;
      um_q    <= 1'b0;
      tag_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      // Default is the IDLE word with a zero tag
      opm_q  <= '0;
      ce_q   <= 1'b0;
      um_q   <= 1'b0;
      tag_q  <= '0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_hs) begin
            if (alu_if.cmd_op[1]) begin
              done_q <= 1'b1;  // reserved op: consumed, no work
            end else begin
              op_q    <= alu_if.cmd_op[0];
              len_q   <= (alu_if.cmd_len == 8'd0) ? CNT_W'(256) : CNT_W'(alu_if.cmd_len);
              cnt_q   <= '0;
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          um_q <= 1'b1;
          if (alu_if.in_valid) begin
            cnt_q <= cnt_d;
            ce_q  <= 1'b1;
            // CMAC restarts the accumulator on its first sample only
            opm_q <= (!op_q || (cnt_q == '0)) ? OPM_LOAD : OPM_ACC;
            tag_q <= {(!op_q || last_smp), last_smp};
            if (last_smp) begin
              state_q <= S_DRAIN;
              dcnt_q  <= '0;
            end
          end else begin
            opm_q <= OPM_HOLD;
          end
        end
        S_DRAIN: begin
          if (done_q) begin
            state_q <= S_IDLE;  // leaves with the IDLE word
          end else begin
            opm_q <= OPM_HOLD;
            um_q  <= 1'b1;
            if (dcnt_q == DCNT_W'(ALU_LAT)) begin
              done_q <= 1'b1;
            end else begin
              dcnt_q <= dcnt_q + DCNT_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tags travel alongside the ALU pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ALU_LAT); i++) tag_sr_q[i] <= '0;
    end else begin
      tag_sr_q[0] <= tag_q;
      for (int i = 1; i < int'(ALU_LAT); i++) tag_sr_q[i] <= tag_sr_q[i-1];
    end
  end

  assign alu_if.cmd_ready = (state_q == S_IDLE);
  assign alu_if.in_ready  = (state_q == S_RUN);
  assign alu_if.busy      = (state_q != S_IDLE);
  assign alu_if.alumode   = '0;
  assign alu_if.inmode    = '0;
  assign alu_if.opmode    = {4{opm_q}};
  assign alu_if.cea2      = {4{ce_q}};
  assign alu_if.ceb2      = {4{ce_q}};
  assign alu_if.usemult   = {4{um_q}};
  assign alu_if.out_valid = tag_sr_q[ALU_LAT-1][1];
  assign alu_if.out_last  = tag_sr_q[ALU_LAT-1][0];
  assign alu_if.done      = done_q;

endmodule

// File: tb/tb_complex_alu_seq.sv
// Self-checking bench for complex_alu_seq: cycle model of the sequencer with
// scoreboard queues for expected results and done pulses.
module tb_complex_alu_seq;

  localparam int unsigned LAT   = 5;
  localparam int          LIMIT = 2000;

  localparam logic [6:0] W_LOAD = 7'b0000101;
  localparam logic [6:0] W_ACC  = 7'b0100101;
  localparam logic [6:0] W_HOLD = 7'b0100000;

  logic clk;
  logic rst;

  complex_alu_seq_if ifc ();

  complex_alu_seq #(.ALU_LAT(LAT)) dut (
    .clk    (clk),
    .rst    (rst),
    .alu_if (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- model / scoreboard ----------------
  typedef enum {M_IDLE, M_RUN, M_DRAIN} mstate_t;
  typedef struct {
    int unsigned cyc;
    logic        last;
  } res_t;

  res_t        res_q[$];
  int unsigned exp_done_q[$];

  mstate_t     m_state = M_IDLE;
  int          m_len   = 0;
  int          m_cnt   = 0;
  logic        m_cmac  = 1'b0;
  int unsigned m_done_cyc = 0;
  int unsigned cyc   = 0;
  logic [6:0]  e_op  = '0;
  logic        e_ce  = 1'b0;
  logic        e_um  = 1'b0;
  int          n_res = 0;
  int          n_done = 0;
  int          n_in_hs = 0;

  always @(negedge clk) begin
    logic [79:0] got_w;
    logic [79:0] exp_w;
    cyc++;
    // compare this cycle's outputs
    check("cmd_ready", 80'(ifc.cmd_ready), 80'(m_state == M_IDLE));
    check("in_ready",  80'(ifc.in_ready),  80'(m_state == M_RUN));
    check("busy",      80'(ifc.busy),      80'(m_state != M_IDLE));
    got_w = 80'({ifc.alumode, ifc.inmode, ifc.opmode, ifc.cea2, ifc.ceb2, ifc.usemult});
    exp_w = 80'({16'h0, 20'h0, {4{e_op}}, {4{e_ce}}, {4{e_ce}}, {4{e_um}}});
    check("ctrl_word", got_w, exp_w);

    while (res_q.size() > 0 && res_q[0].cyc < cyc) begin
      check("out_missing_at", 80'(cyc), 80'(res_q[0].cyc));
      void'(res_q.pop_front());
    end
    if (ifc.out_valid) begin
      if (res_q.size() == 0) begin
        check("out_valid_spurious", 80'(ifc.out_valid), 80'(0));
      end else begin
        res_t e;
        e = res_q.pop_front();
        check("out_cycle", 80'(cyc), 80'(e.cyc));
        check("out_last",  80'(ifc.out_last), 80'(e.last));
        n_res++;
      end
    end else begin
      check("out_last_no_valid", 80'(ifc.out_last), 80'(0));
    end

    while (exp_done_q.size() > 0 && exp_done_q[0] < cyc) begin
      check("done_missing_at", 80'(cyc), 80'(exp_done_q[0]));
      void'(exp_done_q.pop_front());
    end
    if (ifc.done) begin
      if (exp_done_q.size() == 0) begin
        check("done_spurious", 80'(ifc.done), 80'(0));
      end else begin
        check("done_cycle", 80'(cyc), 80'(exp_done_q.pop_front()));
        n_done++;
      end
    end

    if (ifc.in_valid && ifc.in_ready) n_in_hs++;

    // advance model; e_* become the expected word for the next cycle
    e_op = '0; e_ce = 1'b0; e_um = 1'b0;
    if (rst) begin
      res_q.delete();
      exp_done_q.delete();
      m_state = M_IDLE;
    end else begin
      case (m_state)
        M_IDLE: begin
          if (ifc.cmd_valid) begin
            if (ifc.cmd_op[1]) begin
              exp_done_q.push_back(cyc + 1);
            end else begin
              m_cmac  = ifc.cmd_op[0];
              m_len   = (ifc.cmd_len == 8'd0) ? 256 : int'(ifc.cmd_len);
              m_cnt   = 0;
              m_state = M_RUN;
            end
          end
        end
        M_RUN: begin
          e_um = 1'b1;
          if (ifc.in_valid) begin
            logic lst;
            m_cnt++;
            lst  = (m_cnt == m_len);
            e_ce = 1'b1;
            e_op = (!m_cmac || m_cnt == 1) ? W_LOAD : W_ACC;
            if (!m_cmac || lst) res_q.push_back('{cyc: cyc + 1 + LAT, last: lst});
            if (lst) begin
              m_state    = M_DRAIN;
              m_done_cyc = cyc + LAT + 2;
              exp_done_q.push_back(m_done_cyc);
            end
          end else begin
            e_op = W_HOLD;
          end
        end
        default: begin
          if (cyc == m_done_cyc) begin
            m_state = M_IDLE;
          end else begin
            e_op = W_HOLD;
            e_um = 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] len);
    bit ok;
    ok = 1'b0;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = op;
    ifc.cmd_len   = len;
    for (int w = 0; w < LIMIT && !ok; w++) begin
      @(negedge clk);
      ok = ifc.cmd_ready;
      tick();
    end
    if (!ok) check("cmd_hs_timeout", 80'(ifc.cmd_ready), 80'(1));
    ifc.cmd_valid = 1'b0;
  endtask

  // mode 0: back-to-back, 1: one gap before the 2nd sample, 2: random gaps
  task automatic send_samples(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      int g;
      bit ok;
      g  = 0;
      ok = 1'b0;
      if (mode == 1 && i == 1) g = 1;
      else if (mode == 2) g = int'($urandom_range(0, 2));
      ifc.in_valid = 1'b0;
      repeat (g) tick();
      ifc.in_valid = 1'b1;
      for (int w = 0; w < LIMIT && !ok; w++) begin
        @(negedge clk);
        ok = ifc.in_ready;
        tick();
      end
      if (!ok) check("in_hs_timeout", 80'(ifc.in_ready), 80'(1));
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int w = 0; w < LIMIT && !ok; w++) begin
      @(negedge clk);
      ok = !ifc.busy;
      tick();
    end
    if (!ok) check("idle_timeout", 80'(ifc.busy), 80'(0));
    repeat (2) tick();
  endtask

  initial begin
    int r0, d0, h0;
    rst = 1'b1;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = '0;
    ifc.cmd_len   = '0;
    ifc.in_valid  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // CMUL len 3, continuous samples
    send_cmd(2'b00, 8'd3);
    send_samples(3, 0);
    wait_idle();

    // CMAC len 4, samples 1-0-1-1-1
    send_cmd(2'b01, 8'd4);
    send_samples(4, 1);
    wait_idle();

    // second command offered while the first is running
    send_cmd(2'b00, 8'd4);
    fork
      send_samples(4, 0);
      send_cmd(2'b01, 8'd3);
    join
    send_samples(3, 0);
    wait_idle();

    // reserved ops
    d0 = n_done;
    send_cmd(2'b10, 8'd5);
    send_cmd(2'b11, 8'd0);
    repeat (3) tick();
    check("reserved_done_count", 80'(n_done - d0), 80'(2));

    // cmd_len 0 -> 256 samples, random gaps
    r0 = n_res; d0 = n_done; h0 = n_in_hs;
    send_cmd(2'b00, 8'd0);
    send_samples(256, 2);
    wait_idle();
    check("len0_samples", 80'(n_in_hs - h0), 80'(256));
    check("len0_results", 80'(n_res - r0), 80'(256));
    check("len0_done",    80'(n_done - d0), 80'(1));

    // reset on the 2nd of 4 CMAC samples
    r0 = n_res; d0 = n_done;
    send_cmd(2'b01, 8'd4);
    send_samples(1, 0);
    ifc.in_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifc.in_valid = 1'b0;
    repeat (LAT + 6) tick();
    check("abort_no_done",   80'(n_done - d0), 80'(0));
    check("abort_no_result", 80'(n_res - r0), 80'(0));

    // randomized commands
    for (int k = 0; k < 6; k++) begin
      send_cmd(2'(int'($urandom_range(0, 1))), 8'(int'($urandom_range(1, 9))));
      send_samples(m_len, 2);
      wait_idle();
    end

    repeat (LAT + 4) tick();
    check("results_drained", 80'(res_q.size()), 80'(0));
    check("dones_drained",   80'(exp_done_q.size()), 80'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
